// File: rtl/time_entry_ctrl_if.sv
// time_entry_ctrl_if: keypad strobes in, entered digits and flags out.
// master drives the keypad side; slave is the entry controller.
interface time_entry_ctrl_if;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key;
    logic       time_key;
    logic       alarm_key;
    logic [3:0] new_time_ms_hr;
    logic [3:0] new_time_ls_hr;
    logic [3:0] new_time_ms_min;
    logic [3:0] new_time_ls_min;
    logic       load_new_c;
    logic       load_new_a;
    logic       show_new_time;
    logic       show_a;
    logic       entry_error;

    modport master (
        output one_second, key_valid, key, time_key, alarm_key,
        input  new_time_ms_hr, new_time_ls_hr,
        input  new_time_ms_min, new_time_ls_min,
        input  load_new_c, load_new_a,
        input  show_new_time, show_a, entry_error
    );

    modport slave (
        input  one_second, key_valid, key, time_key, alarm_key,
        output new_time_ms_hr, new_time_ls_hr,
        output new_time_ms_min, new_time_ls_min,
        output load_new_c, load_new_a,
        output show_new_time, show_a, entry_error
    );
endinterface

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad HH:MM entry, validation, commit to time or alarm.
// All outputs registered; an inactivity timeout abandons stale entries.
module time_entry_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic             clk,
    input  logic             reset,
    time_entry_ctrl_if.slave bus
);
    localparam int unsigned   CW   = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        COMMIT_C,
        COMMIT_A,
        SHOW_ALARM
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
    logic          load_c_q, load_a_q, show_nt_q, show_a_q, err_q;
    logic          digit, cmd, entry_ok, timeout;

    // Key decode, entry validation and saturating inactivity count
    always_comb begin
        digit    = bus.key_valid && (bus.key <= 4'd9);
        cmd      = bus.time_key || bus.alarm_key;
        entry_ok = ((ms_hr_q < 4'd2 && ls_hr_q <= 4'd9) ||
                    (ms_hr_q == 4'd2 && ls_hr_q <= 4'd3)) &&
                   (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9);
        cnt_d    = cnt_q;
        if (bus.one_second && cnt_q != TMAX)
            cnt_d = cnt_q + 1'b1;
        timeout  = bus.one_second && (cnt_d == TMAX);
    end

    // Entry state machine with registered digit buffer and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ms_hr_q   <= '0;
            ls_hr_q   <= '0;
            ms_min_q  <= '0;
            ls_min_q  <= '0;
            load_c_q  <= 1'b0;
            load_a_q  <= 1'b0;
            show_nt_q <= 1'b0;
            show_a_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            load_c_q <= 1'b0;
            load_a_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.time_key) begin
                        state_q <= IDLE;
                    end else if (bus.alarm_key) begin
                        state_q  <= SHOW_ALARM;
                        show_a_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (digit) begin
                        {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} <=
                            {ls_hr_q, ms_min_q, ls_min_q, bus.key};
                        state_q   <= ENTRY;
                        show_nt_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                ENTRY: begin
                    if (cmd) begin
                        show_nt_q <= 1'b0;
                        cnt_q     <= '0;
                        if (entry_ok) begin
                            state_q  <= bus.time_key ? COMMIT_C : COMMIT_A;
                            load_c_q <= bus.time_key;
                            load_a_q <= !bus.time_key;
                        end else begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                            {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} <= '0;
                        end
                    end else if (digit) begin
                        {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} <=
                            {ls_hr_q, ms_min_q, ls_min_q, bus.key};
                        cnt_q <= '0;
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        show_nt_q <= 1'b0;
                        cnt_q     <= '0;
                        {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} <= '0;
                    end
                end
                COMMIT_C, COMMIT_A: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} <= '0;
                end
                SHOW_ALARM: begin
                    if (cmd) begin
                        state_q  <= IDLE;
                        show_a_q <= 1'b0;
                        cnt_q    <= '0;
                    end else if (digit) begin
                        {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} <=
                            {12'h000, bus.key};
                        state_q   <= ENTRY;
                        show_a_q  <= 1'b0;
                        show_nt_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (timeout) begin
                        state_q  <= IDLE;
                        show_a_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    show_nt_q <= 1'b0;
                    show_a_q  <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign bus.new_time_ms_hr  = ms_hr_q;
    assign bus.new_time_ls_hr  = ls_hr_q;
    assign bus.new_time_ms_min = ms_min_q;
    assign bus.new_time_ls_min = ls_min_q;
    assign bus.load_new_c      = load_c_q;
    assign bus.load_new_a      = load_a_q;
    assign bus.show_new_time   = show_nt_q;
    assign bus.show_a          = show_a_q;
    assign bus.entry_error     = err_q;
endmodule
